// File: rtl/vga_pkg.sv
// Shared VGA raster constants, coordinate type and horizontal phase decode
// for the timing generator and the full-screen renderers.
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  // Visible screen size shared with the sprite/ROM renderers.
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Default 640x480@60 porch and sync widths.
  localparam int unsigned H_FP_DEF       = 16;
  localparam int unsigned H_SYNC_DEF     = 96;
  localparam int unsigned H_BP_DEF       = 48;
  localparam int unsigned V_FP_DEF       = 10;
  localparam int unsigned V_SYNC_DEF     = 2;
  localparam int unsigned V_BP_DEF       = 33;
  localparam int unsigned SYNC_DELAY_DEF = 1;

  localparam int unsigned H_TOTAL = SCREEN_W + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = SCREEN_H + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned FRAME_CNT_W = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    H_PH_VISIBLE,
    H_PH_FP,
    H_PH_SYNC,
    H_PH_BP
  } h_phase_t;

  // Classify a column into its horizontal phase given the phase boundaries.
  function automatic h_phase_t h_phase(coord_t x, coord_t vis_end,
                                       coord_t sync_beg, coord_t sync_end);
    if (x < vis_end)       return H_PH_VISIBLE;
    else if (x < sync_beg) return H_PH_FP;
    else if (x < sync_end) return H_PH_SYNC;
    else                   return H_PH_BP;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the renderers and game logic.
// With VGA_TIMING_FRAME_CNT_EN defined the bundle also carries frame_cnt.
interface vga_timing_gen_if;
  import vga_pkg::*;

  coord_t DrawX;
  coord_t DrawY;
  logic   blank;
  logic   hs;
  logic   vs;
  logic   frame_start;
  logic   line_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;
`endif

  modport master (
    output DrawX, DrawY, blank, hs, vs, frame_start, line_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , frame_cnt
`endif
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, frame_start, line_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , frame_cnt
`endif
  );

endinterface

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register for a sync signal; every stage resets to 1 so
// an idle (high) sync level is flushed out after reset.
module vga_sync_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  // Shift the new sample in at bit 0; the oldest stage drives q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '1;
    else        sr <= (sr << 1) | DEPTH'(d);
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator. All outputs are registered from
// the next-state counter values so they line up with DrawX/DrawY.
// Optional: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = SCREEN_W,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_VISIBLE  = SCREEN_H,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned SYNC_DELAY = SYNC_DELAY_DEF
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST     = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
  localparam coord_t H_SYNC_BEG = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t H_SYNC_END = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
  localparam coord_t V_SYNC_BEG = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t V_SYNC_END = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  coord_t   x_q, y_q;
  coord_t   x_n, y_n;
  h_phase_t h_phase_n;
  logic     blank_n, hs_raw_n, vs_raw_n, fs_n, ls_n;
  logic     blank_q, hs_raw_q, vs_raw_q, fs_q, ls_q;

  // Next raster position and the output flags that describe it.
  always_comb begin
    x_n       = x_q + coord_t'(1);
    y_n       = y_q;
    if (x_q == H_LAST) begin
      x_n = '0;
      y_n = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
    end
    h_phase_n = h_phase(x_n, H_VIS_END, H_SYNC_BEG, H_SYNC_END);
    blank_n   = (h_phase_n == H_PH_VISIBLE) && (y_n < V_VIS_END);
    hs_raw_n  = (h_phase_n != H_PH_SYNC);
    vs_raw_n  = !((y_n >= V_SYNC_BEG) && (y_n < V_SYNC_END));
    fs_n      = (x_n == '0) && (y_n == '0);
    ls_n      = (x_n == '0);
  end

  // Raster counters and undelayed outputs; reset parks on the last position
  // so the first edge after release lands on (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= H_LAST;
      y_q      <= V_LAST;
      blank_q  <= 1'b0;
      hs_raw_q <= 1'b1;
      vs_raw_q <= 1'b1;
      fs_q     <= 1'b0;
      ls_q     <= 1'b0;
    end else begin
      x_q      <= x_n;
      y_q      <= y_n;
      blank_q  <= blank_n;
      hs_raw_q <= hs_raw_n;
      vs_raw_q <= vs_raw_n;
      fs_q     <= fs_n;
      ls_q     <= ls_n;
    end
  end

  assign vga.DrawX       = x_q;
  assign vga.DrawY       = y_q;
  assign vga.blank       = blank_q;
  assign vga.frame_start = fs_q;
  assign vga.line_start  = ls_q;

  // Sync outputs delayed to match the renderer pixel pipeline.
  generate
    if (SYNC_DELAY == 0) begin : g_sync_direct
      assign vga.hs = hs_raw_q;
      assign vga.vs = vs_raw_q;
    end else begin : g_sync_delayed
      vga_sync_delay #(.DEPTH(SYNC_DELAY)) u_hs_delay (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .d     (hs_raw_q),
        .q     (vga.hs)
      );
      vga_sync_delay #(.DEPTH(SYNC_DELAY)) u_vs_delay (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .d     (vs_raw_q),
        .q     (vga.vs)
      );
    end
  endgenerate

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   fs_seen_q;

  // Count frame starts; the first one after reset is frame 0.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      fs_seen_q   <= 1'b0;
    end else if (fs_n) begin
      fs_seen_q <= 1'b1;
      if (fs_seen_q) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing with sync delay
// 0 and 1, plus a shrunken raster with delay 2 for frame-level behaviour),
// each checked cycle by cycle against a scoreboard fed by a reference model.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int unsigned NDUT = 3;

  typedef logic [24:0] snap_t;
  typedef struct packed {
    int         x;
    int         y;
    logic [4:0] hh;
    logic [4:0] vh;
  } mstate_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #20 clk = ~clk;

  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();
  vga_timing_gen_if ifc ();

  vga_timing_gen #(.SYNC_DELAY(0)) dut_a (.vga_clk(clk), .reset_n(reset_n), .vga(ifa));
  vga_timing_gen #(.SYNC_DELAY(1)) dut_b (.vga_clk(clk), .reset_n(reset_n), .vga(ifb));
  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_DELAY(2)
  ) dut_c (.vga_clk(clk), .reset_n(reset_n), .vga(ifc));

  snap_t obs [NDUT];
  assign obs[0] = {ifa.DrawX, ifa.DrawY, ifa.blank, ifa.hs, ifa.vs, ifa.frame_start, ifa.line_start};
  assign obs[1] = {ifb.DrawX, ifb.DrawY, ifb.blank, ifb.hs, ifb.vs, ifb.frame_start, ifb.line_start};
  assign obs[2] = {ifc.DrawX, ifc.DrawY, ifc.blank, ifc.hs, ifc.vs, ifc.frame_start, ifc.line_start};

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic snap_t snap(int x, int y, logic b, logic h, logic v, logic f, logic l);
    return {coord_t'(x), coord_t'(y), b, h, v, f, l};
  endfunction

  // Reference raster model per instance, scoreboard push on posedge, pop on negedge.
  for (genvar g = 0; g < NDUT; g++) begin : g_model
    localparam int HV = (g == 2) ? 16 : 640;
    localparam int HF = (g == 2) ? 2  : 16;
    localparam int HS = (g == 2) ? 4  : 96;
    localparam int HB = (g == 2) ? 3  : 48;
    localparam int VV = (g == 2) ? 12 : 480;
    localparam int VF = (g == 2) ? 2  : 10;
    localparam int VS = 2;
    localparam int VB = (g == 2) ? 3  : 33;
    localparam int D  = g;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    mstate_t ms;
    snap_t   sb [$];

    function automatic mstate_t m_reset();
      mstate_t s;
      s.x  = HT - 1;
      s.y  = VT - 1;
      s.hh = '1;
      s.vh = '1;
      return s;
    endfunction

    function automatic mstate_t m_step(mstate_t s);
      mstate_t n;
      logic hr, vr;
      n = s;
      if (s.x == HT - 1) begin
        n.x = 0;
        n.y = (s.y == VT - 1) ? 0 : s.y + 1;
      end else begin
        n.x = s.x + 1;
      end
      hr   = !(n.x >= HV + HF && n.x < HV + HF + HS);
      vr   = !(n.y >= VV + VF && n.y < VV + VF + VS);
      n.hh = {s.hh[3:0], hr};
      n.vh = {s.vh[3:0], vr};
      return n;
    endfunction

    function automatic snap_t m_expect(mstate_t s);
      return snap(s.x, s.y, (s.x < HV) && (s.y < VV), s.hh[D], s.vh[D],
                  (s.x == 0) && (s.y == 0), s.x == 0);
    endfunction

    always @(posedge clk) begin
      if (!reset_n) begin
        ms <= m_reset();
      end else begin
        ms <= m_step(ms);
        sb.push_back(m_expect(m_step(ms)));
      end
    end

    always @(negedge clk) begin
      if (sb.size() > 0) check($sformatf("raster%0d", g), 32'(obs[g]), 32'(sb.pop_front()));
    end
  end

  int a_blank_fall = -1, a_hs_start = -1, a_hs_len = 0, a_y1 = -1, a_xprev = -1;
  int b_hs_start = -1;
  int c_f1 = -1, c_f2 = -1, c_fs_n = 0, c_vs_low = 0, c_vs_fall = -1, c_ls = 0;
  logic a_prev_blank = 1'b0, a_hs_done = 1'b0, found = 1'b0;
  int a_prev_x = 0;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_a", 32'(obs[0]), 32'(snap(799, 524, 0, 1, 1, 0, 0)));
    check("rst_b", 32'(obs[1]), 32'(snap(799, 524, 0, 1, 1, 0, 0)));
    check("rst_c", 32'(obs[2]), 32'(snap(24, 18, 0, 1, 1, 0, 0)));
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("rst_cnt", 32'(ifc.frame_cnt), 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 1; i <= 1950; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("first_a", 32'(obs[0]), 32'(snap(0, 0, 1, 1, 1, 1, 1)));
        check("first_b", 32'(obs[1]), 32'(snap(0, 0, 1, 1, 1, 1, 1)));
        check("first_c", 32'(obs[2]), 32'(snap(0, 0, 1, 1, 1, 1, 1)));
      end
      // default raster, delay 0
      if (a_blank_fall < 0 && a_prev_blank && !ifa.blank) a_blank_fall = int'(ifa.DrawX);
      a_prev_blank = ifa.blank;
      if (!ifa.hs) begin
        if (a_hs_start < 0) a_hs_start = int'(ifa.DrawX);
        if (!a_hs_done) a_hs_len++;
      end else if (a_hs_start >= 0) begin
        a_hs_done = 1'b1;
      end
      if (ifa.line_start && i > 1 && a_y1 < 0) begin
        a_y1    = int'(ifa.DrawY);
        a_xprev = a_prev_x;
      end
      a_prev_x = int'(ifa.DrawX);
      // default raster, delay 1
      if (!ifb.hs && b_hs_start < 0) b_hs_start = int'(ifb.DrawX);
      // small raster, delay 2
      if (ifc.frame_start) begin
        if (c_fs_n == 0) c_f1 = i;
        if (c_fs_n == 1) c_f2 = i;
        c_fs_n++;
      end
      if (c_fs_n == 1 && !ifc.vs) c_vs_low++;
      if (c_fs_n == 1 && ifc.line_start) c_ls++;
      if (!ifc.vs && c_vs_fall < 0) c_vs_fall = int'(ifc.DrawY) * 1024 + int'(ifc.DrawX);
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (i == 1)    check("cnt_first", 32'(ifc.frame_cnt), 32'd0);
      if (i == 1500) check("cnt_c_3frames", 32'(ifc.frame_cnt), 32'd3);
      if (i == 1500) check("cnt_a_same_frame", 32'(ifa.frame_cnt), 32'd0);
`endif
    end

    check("a_blank_fall_x", 32'(a_blank_fall), 32'd640);
    check("a_hs_start_x",   32'(a_hs_start),   32'd656);
    check("a_hs_len",       32'(a_hs_len),     32'd96);
    check("a_wrap_y",       32'(a_y1),         32'd1);
    check("a_wrap_prev_x",  32'(a_xprev),      32'd799);
    check("b_hs_start_x",   32'(b_hs_start),   32'd657);
    check("c_frame_period", 32'(c_f2 - c_f1),  32'd475);
    check("c_vs_low_len",   32'(c_vs_low),     32'd50);
    check("c_vs_fall_pos",  32'(c_vs_fall),    32'(14 * 1024 + 2));
    check("c_line_starts",  32'(c_ls),         32'd19);

    // Reset in the middle of a frame.
    for (int k = 0; k < 600 && !found; k++) begin
      @(negedge clk);
      if (ifc.DrawX == 10'd10 && ifc.DrawY == 10'd8) found = 1'b1;
    end
    check("mid_wait", 32'(found), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_a", 32'(obs[0]), 32'(snap(799, 524, 0, 1, 1, 0, 0)));
    check("mid_rst_b", 32'(obs[1]), 32'(snap(799, 524, 0, 1, 1, 0, 0)));
    check("mid_rst_c", 32'(obs[2]), 32'(snap(24, 18, 0, 1, 1, 0, 0)));
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("mid_rst_cnt", 32'(ifc.frame_cnt), 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("restart_b", 32'(obs[1]), 32'(snap(0, 0, 1, 1, 1, 1, 1)));
    check("restart_c", 32'(obs[2]), 32'(snap(0, 0, 1, 1, 1, 1, 1)));
    repeat (500) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.
- Produces pixel coordinates DrawX/DrawY and an active-high visible flag `blank` for the full-screen sprite/ROM renderers downstream.
- Produces hs/vs sync outputs delayed to line up with the renderers' registered colour outputs.
- Also emits a per-frame strobe, which the game logic uses to step its state once per frame.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, horizontal sync width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_DELAY, 1, extra clocks of delay applied to hs/vs (0..4), matching the renderer's pixel pipeline depth

Ports:
- vga_clk  input  1  pixel clock, 25 MHz
- reset_n  input  1  asynchronous active-low reset
- DrawX  output  10  current pixel column, 0..H_TOTAL-1
- DrawY  output  10  current line, 0..V_TOTAL-1
- blank  output  1  1 = visible pixel (DrawX<640 and DrawY<480); renderers draw only when high
- hs  output  1  horizontal sync, active-low, delayed by SYNC_DELAY clocks
- vs  output  1  vertical sync, active-low, delayed by SYNC_DELAY clocks
- frame_start  output  1  one-clock pulse coincident with DrawX=0, DrawY=0
- line_start  output  1  one-clock pulse coincident with DrawX=0 on every line

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters = 800; V_TOTAL = sum of the V_* parameters = 525. All compares use 10-bit unsigned arithmetic.
- Reset (async, reset_n=0):
  - DrawX=799, DrawY=524, i.e. the last raster position.
  - blank=0, hs=1, vs=1, frame_start=0, line_start=0.
  - All sync delay-line stages are set to 1.
- First rising edge after reset_n deasserts: DrawX=0, DrawY=0, blank=1, frame_start=1.
- Horizontal counter: each clock DrawX increments. When DrawX=799, the next value is 0 (wrap).
- Vertical counter: advances only on a horizontal wrap. When DrawY=524 and DrawX=799 coincide, both wrap to 0 on the same edge.
- All outputs are registered and computed from next-state counter values, so every output is aligned with the DrawX/DrawY it describes. There is no combinational output path.
- Undelayed sync windows:
  - hs_raw=0 for DrawX in 656..751.
  - vs_raw=0 for DrawY in 490..491, over full lines; vs is not gated by DrawX.
- hs/vs are hs_raw/vs_raw passed through a shift register of SYNC_DELAY stages. With SYNC_DELAY=0, hs/vs align with DrawX/DrawY.
- blank=1 only when DrawX<640 and DrawY<480.
- frame_start=1 exactly when (DrawX,DrawY)=(0,0). line_start=1 exactly when DrawX=0.
- Reset mid-frame: all outputs return immediately to reset values. The raster restarts cleanly at (0,0) with no partial sync pulse beyond the delay-line flush.
- The counters are an implicit two-level state machine; there is no other FSM. H phases are VISIBLE, FP, SYNC, BP, decoded from DrawX ranges.

Optional Feature:
- VGA_TIMING_FRAME_CNT_EN defined:
  - Adds output frame_cnt [15:0].
  - Resets to 0 and increments on each edge where frame_start goes high, except the first after reset, which reads 0.
  - Wraps 65535 -> 0. Used for animation timing.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package vga_pkg holds:
  - localparams H_TOTAL, V_TOTAL and the default porch/sync values;
  - typedef coord_t = logic [9:0];
  - the 640x480 constants shared with the sprite renderers.
- One sub-module, vga_sync_delay: a parameterised-depth shift register with reset value 1, instantiated once per sync signal.

Test Plan:
- Release reset_n -> first edge DrawX=0, DrawY=0, blank=1, frame_start=1, hs=1, vs=1.
- Run one line -> blank falls when DrawX=640; with SYNC_DELAY=0, hs=0 for exactly 96 clocks starting at DrawX=656; DrawX wraps 799 -> 0 and DrawY increments 0 -> 1.
- Run one full frame -> exactly 420000 clocks between frame_start pulses; vs=0 for exactly 1600 clocks starting at DrawY=490, DrawX=0; line_start seen 525 times.
- SYNC_DELAY=1 -> hs falls on the edge where DrawX=657 (one clock after the raw window start); vs behaves the same way, delayed by one clock.
- Assert reset_n at DrawX=300, DrawY=200 -> outputs immediately read 799/524/blank=0/hs=1/vs=1; after release, the raster restarts at (0,0).
- With VGA_TIMING_FRAME_CNT_EN: after 3 complete frames past the reset-release frame, frame_cnt=3.
